// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, addresses the instruction ROM and
// buffers {pc, instruction} pairs in a small FIFO toward decode (valid/ready).
// Supports start, redirect with flush, and halt on an all-zero fetched word.
module fetch_sequencer #(
    parameter int unsigned     PC_W         = 16,
    parameter int unsigned     INSTR_W      = 32,
    parameter int unsigned     PC_STEP      = 2,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int unsigned     DEPTH        = 2,
    parameter int unsigned     HALT_ON_ZERO = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [PC_W-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               redir_valid,
    input  logic [PC_W-1:0]    redir_pc,
    output logic               busy,
    output logic               halted
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } state_t;

    state_t state, state_next;

    logic [PC_W-1:0]    pc, pc_next;
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [PC_W-1:0]    mem_pc    [DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [AW:0]        count;

    logic empty, full, pop, push, redir, flush, zero_word;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign pop       = !empty && out_ready;
    assign redir     = redir_valid && (state != IDLE);
    assign zero_word = (HALT_ON_ZERO != 0) && (imem_instr == '0);

    assign imem_pc   = pc;
    assign out_valid = !empty;
    assign out_instr = empty ? '0 : mem_instr[rd_ptr];
    assign out_pc    = empty ? '0 : mem_pc[rd_ptr];
    assign busy      = (state == FETCH);
    assign halted    = (state == HALT);

    // State and program counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Next state, push decision and next pc; redirect overrides halt detection and push
    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        flush      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                if (zero_word) begin
                    state_next = HALT;
                end else if (!full || pop) begin
                    push    = 1'b1;
                    pc_next = pc + PC_W'(PC_STEP);
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: state_next = IDLE;
        endcase
        if (redir) begin
            push       = 1'b0;
            flush      = 1'b1;
            state_next = FETCH;
            pc_next    = redir_pc & ~PC_W'(1);
        end
    end

    // FIFO storage and pointers; a flush discards everything left after this cycle's pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= imem_instr;
                mem_pc[wr_ptr]    <= pc;
                wr_ptr            <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule
